// File: rtl/sram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sram_arbiter
// Description : Two-port fair arbiter driving an asynchronous byte-wide SRAM
//               through a setup / strobe / hold / done sequence.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_arbiter #(
  parameter int RD_WAIT  = 1,
  parameter int WR_WIDTH = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        a_req,
  input  logic        a_we,
  input  logic [15:0] a_addr,
  input  logic [7:0]  a_wdata,
  output logic        a_ack,
  output logic [7:0]  a_rdata,
  input  logic        b_req,
  input  logic        b_we,
  input  logic [15:0] b_addr,
  input  logic [7:0]  b_wdata,
  output logic        b_ack,
  output logic [7:0]  b_rdata,
  output logic [15:0] sram_addr,
  output logic [7:0]  sram_dout,
  output logic        sram_dout_en,
  input  logic [7:0]  sram_din,
  output logic        sram_cs1_bar,
  output logic        sram_cs2,
  output logic        sram_we_bar,
  output logic        sram_oe_bar,
  output logic        busy
);

  localparam logic [2:0] c_IDLE    = 3'd0;
  localparam logic [2:0] c_SETUP   = 3'd1;
  localparam logic [2:0] c_RSTROBE = 3'd2;
  localparam logic [2:0] c_WSTROBE = 3'd3;
  localparam logic [2:0] c_WHOLD   = 3'd4;
  localparam logic [2:0] c_DONE    = 3'd5;

  localparam logic [2:0] c_RD_CNT = 3'(RD_WAIT);
  localparam logic [2:0] c_WR_CNT = 3'(WR_WIDTH - 1);

  logic [2:0]  r_state;
  logic [2:0]  r_cnt;
  logic        r_we;
  logic [15:0] r_addr;
  logic [7:0]  r_wdata;
  logic        r_sel_b;
  logic        r_last_b;
  logic [7:0]  r_a_rdata;
  logic [7:0]  r_b_rdata;

  logic [2:0]  w_next;
  logic        w_grant_b;
  logic        w_accept;

  // On contention B wins only when A was granted last.
  assign w_grant_b = b_req && (!a_req || !r_last_b);
  assign w_accept  = (r_state == c_IDLE) && (a_req || b_req);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= c_IDLE;
      r_cnt     <= 3'd0;
      r_we      <= 1'b0;
      r_addr    <= 16'd0;
      r_wdata   <= 8'd0;
      r_sel_b   <= 1'b0;
      r_last_b  <= 1'b1;
      r_a_rdata <= 8'd0;
      r_b_rdata <= 8'd0;
    end else begin
      r_state <= w_next;
      if (w_next != r_state) begin
        if (w_next == c_RSTROBE)
          r_cnt <= c_RD_CNT;
        else if (w_next == c_WSTROBE)
          r_cnt <= c_WR_CNT;
        else
          r_cnt <= 3'd0;
      end else if (r_cnt != 3'd0) begin
        r_cnt <= r_cnt - 3'd1;
      end
      if (w_accept) begin
        r_sel_b  <= w_grant_b;
        r_last_b <= w_grant_b;
        r_we     <= w_grant_b ? b_we    : a_we;
        r_addr   <= w_grant_b ? b_addr  : a_addr;
        r_wdata  <= w_grant_b ? b_wdata : a_wdata;
      end
      if ((r_state == c_RSTROBE) && (r_cnt == 3'd0)) begin
        if (r_sel_b)
          r_b_rdata <= sram_din;
        else
          r_a_rdata <= sram_din;
      end
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      c_IDLE:    if (a_req || b_req) w_next = c_SETUP;
      c_SETUP:   w_next = r_we ? c_WSTROBE : c_RSTROBE;
      c_RSTROBE: if (r_cnt == 3'd0) w_next = c_DONE;
      c_WSTROBE: if (r_cnt == 3'd0) w_next = c_WHOLD;
      c_WHOLD:   w_next = c_DONE;
      c_DONE:    w_next = c_IDLE;
      default:   w_next = c_IDLE;
    endcase
  end

  // Controls decode from the state register only, never from the request inputs.
  always_comb begin
    sram_cs1_bar = 1'b1;
    sram_cs2     = 1'b0;
    sram_we_bar  = 1'b1;
    sram_oe_bar  = 1'b1;
    sram_dout_en = 1'b0;
    a_ack        = 1'b0;
    b_ack        = 1'b0;
    busy         = (r_state != c_IDLE);
    case (r_state)
      c_SETUP: begin
        sram_cs1_bar = 1'b0;
        sram_cs2     = 1'b1;
        sram_dout_en = r_we;
      end
      c_RSTROBE: begin
        sram_cs1_bar = 1'b0;
        sram_cs2     = 1'b1;
        sram_oe_bar  = 1'b0;
      end
      c_WSTROBE: begin
        sram_cs1_bar = 1'b0;
        sram_cs2     = 1'b1;
        sram_we_bar  = 1'b0;
        sram_dout_en = 1'b1;
      end
      c_WHOLD: begin
        sram_cs1_bar = 1'b0;
        sram_cs2     = 1'b1;
        sram_dout_en = 1'b1;
      end
      c_DONE: begin
        a_ack = !r_sel_b;
        b_ack = r_sel_b;
      end
      default: ;
    endcase
  end

  assign sram_addr = r_addr;
  assign sram_dout = r_wdata;
  assign a_rdata   = r_a_rdata;
  assign b_rdata   = r_b_rdata;

endmodule
`default_nettype wire
